// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialisation: power wait, PRECHARGE ALL, AUTO REFRESH burst, LOAD MODE.
// Define SDRAM_INIT_FAST_SIM_EN to shorten the power-up wait to 200 cycles for simulation.
module sdram_init_seq #(
    parameter int unsigned T_POWER  = 20000,
    parameter int unsigned T_RP     = 2,
    parameter int unsigned T_RC     = 7,
    parameter int unsigned T_MRD    = 3,
    parameter int unsigned AREF_NUM = 8
) (
    input  logic        clk_100m,
    input  logic        rstn,
    output logic [3:0]  init_cmd,
    output logic [1:0]  init_bank,
    output logic [12:0] init_addr,
    output logic        init_end
);

`ifdef SDRAM_INIT_FAST_SIM_EN
    localparam int unsigned T_PWR_EFF = 200;
`else
    localparam int unsigned T_PWR_EFF = T_POWER;
`endif

    localparam int unsigned PW   = (T_PWR_EFF > 1) ? $clog2(T_PWR_EFF) : 1;
    localparam int unsigned DMAX = (T_RC > T_RP) ? ((T_RC > T_MRD) ? T_RC : T_MRD)
                                                 : ((T_RP > T_MRD) ? T_RP : T_MRD);
    localparam int unsigned DW   = $clog2(DMAX + 1);
    localparam int unsigned AW   = $clog2(AREF_NUM + 1);

    // Spacing counters end at T-2: one cycle goes to the issue state, one to the
    // wait-state transition, so every spacing parameter must be at least 2.
    localparam logic [PW-1:0] PWR_LAST  = PW'(T_PWR_EFF - 1);
    localparam logic [DW-1:0] RP_LAST   = DW'(T_RP - 2);
    localparam logic [DW-1:0] RC_LAST   = DW'(T_RC - 2);
    localparam logic [DW-1:0] MRD_LAST  = DW'(T_MRD - 2);
    localparam logic [AW-1:0] AREF_LAST = AW'(AREF_NUM);

    localparam logic [3:0]  CMD_NOP  = 4'b0111;
    localparam logic [3:0]  CMD_PRE  = 4'b0010;
    localparam logic [3:0]  CMD_AREF = 4'b0001;
    localparam logic [3:0]  CMD_MRS  = 4'b0000;
    localparam logic [12:0] ADDR_ALL = 13'h1FFF;
    localparam logic [12:0] MODE_VAL = 13'h0037;

    typedef enum logic [2:0] {
        IDLE, PRE, TRP, AREF, TRF, MRS, TMRD, END
    } state_t;

    state_t         state;
    logic [PW-1:0]  pwr_cnt;
    logic [DW-1:0]  dly_cnt;
    logic [AW-1:0]  aref_cnt;

    always_ff @(posedge clk_100m or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            pwr_cnt   <= '0;
            dly_cnt   <= '0;
            aref_cnt  <= '0;
            init_cmd  <= CMD_NOP;
            init_bank <= 2'b11;
            init_addr <= ADDR_ALL;
            init_end  <= 1'b0;
        end else begin
            init_cmd  <= CMD_NOP;
            init_bank <= 2'b11;
            init_addr <= ADDR_ALL;
            case (state)
                IDLE: begin
                    if (pwr_cnt == PWR_LAST)
                        state <= PRE;
                    else
                        pwr_cnt <= pwr_cnt + 1'b1;
                end
                PRE: begin
                    init_cmd <= CMD_PRE;
                    dly_cnt  <= '0;
                    state    <= TRP;
                end
                TRP: begin
                    if (dly_cnt == RP_LAST)
                        state <= AREF;
                    else
                        dly_cnt <= dly_cnt + 1'b1;
                end
                AREF: begin
                    init_cmd <= CMD_AREF;
                    aref_cnt <= aref_cnt + 1'b1;
                    dly_cnt  <= '0;
                    state    <= TRF;
                end
                TRF: begin
                    if (dly_cnt == RC_LAST)
                        state <= (aref_cnt == AREF_LAST) ? MRS : AREF;
                    else
                        dly_cnt <= dly_cnt + 1'b1;
                end
                MRS: begin
                    init_cmd  <= CMD_MRS;
                    init_bank <= 2'b00;
                    init_addr <= MODE_VAL;
                    dly_cnt   <= '0;
                    state     <= TMRD;
                end
                TMRD: begin
                    if (dly_cnt == MRD_LAST)
                        state <= END;
                    else
                        dly_cnt <= dly_cnt + 1'b1;
                end
                END: begin
                    init_end <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_init_seq.sv
// Directed bench for sdram_init_seq: full sequence timing, async abort mid-refresh and from END.
module tb_sdram_init_seq;

    logic        clk_100m = 1'b0;
    logic        rstn     = 1'b0;
    logic [3:0]  init_cmd;
    logic [1:0]  init_bank;
    logic [12:0] init_addr;
    logic        init_end;

`ifdef SDRAM_INIT_FAST_SIM_EN
    localparam int TPW = 200;
`else
    localparam int TPW = 20000;
`endif

    int errors = 0;
    int checks = 0;

    sdram_init_seq dut (
        .clk_100m  (clk_100m),
        .rstn      (rstn),
        .init_cmd  (init_cmd),
        .init_bank (init_bank),
        .init_addr (init_addr),
        .init_end  (init_end)
    );

    always #5 clk_100m = ~clk_100m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Hand-derived schedule: PRE at TPW, AREF at TPW+2+7k (k=0..7), LOAD MODE at TPW+58.
    function automatic logic [3:0] exp_cmd(input int c);
        if (c == TPW) return 4'b0010;
        if (c >= TPW + 2 && c <= TPW + 51 && ((c - (TPW + 2)) % 7) == 0) return 4'b0001;
        if (c == TPW + 58) return 4'b0000;
        return 4'b0111;
    endfunction

    task automatic run_seq(input string ph, input int last);
        int bad_cmd = 0;
        int bad_ba  = 0;
        int bad_end = 0;
        int n_aref  = 0;
        logic [3:0] ec;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk_100m);
            #1;
            ec = exp_cmd(c);
            if (init_cmd !== ec) bad_cmd++;
            if (ec == 4'b0000) begin
                if (init_bank !== 2'b00 || init_addr !== 13'h0037) bad_ba++;
            end else begin
                if (init_bank !== 2'b11 || init_addr !== 13'h1FFF) bad_ba++;
            end
            if (init_end !== (c >= TPW + 61)) bad_end++;
            if (init_cmd === 4'b0001) n_aref++;
            if (c == TPW - 1) chk({ph, "_wait_last_nop"}, 32'(init_cmd), 32'h7);
            if (c == TPW) begin
                chk({ph, "_pre_cmd"},  32'(init_cmd),  32'h2);
                chk({ph, "_pre_bank"}, 32'(init_bank), 32'h3);
                chk({ph, "_pre_addr"}, 32'(init_addr), 32'h1FFF);
            end
            if (c == TPW + 1)  chk({ph, "_trp_nop"},    32'(init_cmd), 32'h7);
            if (c == TPW + 2)  chk({ph, "_aref_first"}, 32'(init_cmd), 32'h1);
            if (c == TPW + 8)  chk({ph, "_trc_nop"},    32'(init_cmd), 32'h7);
            if (c == TPW + 9)  chk({ph, "_aref_2nd"},   32'(init_cmd), 32'h1);
            if (c == TPW + 51) chk({ph, "_aref_last"},  32'(init_cmd), 32'h1);
            if (c == TPW + 58) begin
                chk({ph, "_mrs_cmd"},  32'(init_cmd),  32'h0);
                chk({ph, "_mrs_bank"}, 32'(init_bank), 32'h0);
                chk({ph, "_mrs_addr"}, 32'(init_addr), 32'h0037);
            end
            if (c == TPW + 60) chk({ph, "_end_before"}, 32'(init_end), 32'h0);
            if (c == TPW + 61) chk({ph, "_end_rise"},   32'(init_end), 32'h1);
        end
        chk({ph, "_cmd_trace"},  32'(bad_cmd), 32'h0);
        chk({ph, "_addr_trace"}, 32'(bad_ba),  32'h0);
        chk({ph, "_end_trace"},  32'(bad_end), 32'h0);
        if (last >= TPW + 58) chk({ph, "_aref_count"}, 32'(n_aref), 32'd8);
    endtask

    task automatic chk_reset_outputs(input string ph);
        chk({ph, "_rst_cmd"},  32'(init_cmd),  32'h7);
        chk({ph, "_rst_bank"}, 32'(init_bank), 32'h3);
        chk({ph, "_rst_addr"}, 32'(init_addr), 32'h1FFF);
        chk({ph, "_rst_end"},  32'(init_end),  32'h0);
    endtask

    initial begin
        rstn = 1'b0;
        repeat (3) @(posedge clk_100m);
        #1;
        chk_reset_outputs("por");

        @(negedge clk_100m);
        rstn = 1'b1;
        run_seq("run1", TPW + 61 + 1000);
        chk("run1_end_held", 32'(init_end), 32'h1);
        chk("run1_end_cmd",  32'(init_cmd), 32'h7);

        @(negedge clk_100m);
        rstn = 1'b0;
        @(negedge clk_100m);
        rstn = 1'b1;
        run_seq("run2", TPW + 30);
        chk("run2_aref_at_abort", 32'(init_cmd), 32'h1);
        #2;
        rstn = 1'b0;
        #1;
        chk_reset_outputs("abort_refresh");
        repeat (2) @(posedge clk_100m);
        @(negedge clk_100m);
        rstn = 1'b1;
        run_seq("run3", TPW + 70);

        #2;
        rstn = 1'b0;
        #1;
        chk_reset_outputs("abort_end");
        @(negedge clk_100m);
        rstn = 1'b1;
        run_seq("run4", TPW + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_init_seq.md
SDRAM_INIT_SEQ -- requirements
Module: sdram_init_seq

Interface
REQ-001 Parameter T_POWER, default 20000, power-up wait in clk_100m cycles (200 us).
REQ-002 Parameter T_RP, default 2, PRECHARGE-to-next-command spacing in cycles.
REQ-003 Parameter T_RC, default 7, AUTO REFRESH-to-next-command spacing in cycles.
REQ-004 Parameter T_MRD, default 3, LOAD MODE-to-init_end spacing in cycles.
REQ-005 Parameter AREF_NUM, default 8, number of AUTO REFRESH commands.
REQ-006 clk_100m  input  1  100 MHz system clock; all logic on its rising edge.
REQ-007 rstn  input  1  reset, asynchronous, active-low.
REQ-008 init_cmd  output  4  SDRAM command {CS_n,RAS_n,CAS_n,WE_n}.
REQ-009 init_bank  output  2  SDRAM bank address.
REQ-010 init_addr  output  13  SDRAM address bus A12..A0.
REQ-011 init_end  output  1  high once the init sequence completes.

Function
REQ-012 Command encodings SHALL be NOP 4'b0111, PRECHARGE 4'b0010, AUTO REFRESH 4'b0001, LOAD MODE 4'b0000.
REQ-013 All outputs SHALL be registered; each non-NOP command SHALL be driven for exactly one cycle, NOP otherwise.
REQ-014 States: IDLE (power wait), PRE, TRP, AREF, TRF, MRS, TMRD, END.
REQ-015 Cycle 0 = first rising edge after rstn deasserts; IDLE SHALL count cycles 0..T_POWER-1 with NOP driven.
REQ-016 PRECHARGE ALL SHALL be driven at cycle T_POWER with init_bank 2'b11, init_addr 13'h1FFF (A10=1).
REQ-017 First AUTO REFRESH SHALL be driven T_RP cycles after PRECHARGE.
REQ-018 Successive AUTO REFRESH commands SHALL be spaced exactly T_RC cycles; exactly AREF_NUM issued.
REQ-019 LOAD MODE SHALL be driven T_RC cycles after the last AUTO REFRESH, init_bank 2'b00, init_addr 13'h0037.
REQ-020 Mode value 13'h0037: burst length full page (A2:A0=111), sequential (A3=0), CAS latency 3 (A6:A4=011), A8:A7=00, A9=0 burst write, A12:A10=000.
REQ-021 init_end SHALL rise T_MRD cycles after LOAD MODE and hold high (state END) until reset.
REQ-022 In END, outputs SHALL be NOP, init_bank 2'b11, init_addr 13'h1FFF.
REQ-023 During NOP cycles of the sequence init_bank SHALL be 2'b11 and init_addr 13'h1FFF.
REQ-024 Refresh counter SHALL be wide enough for AREF_NUM without wrap; power counter SHALL saturate/stop at T_POWER-1.

Reset
REQ-025 rstn low SHALL immediately force state IDLE, all counters 0, init_cmd NOP, init_bank 2'b11, init_addr 13'h1FFF, init_end 0.
REQ-026 Reset asserted mid-sequence (any state including END) SHALL abort and, after release, restart from the full power-up wait.

Configuration
REQ-027 Macro SDRAM_INIT_FAST_SIM_EN: when defined, power-up wait SHALL be 200 cycles regardless of T_POWER; when undefined, T_POWER cycles; all other timing identical.

Verification
REQ-028 Defaults, no macro, release reset -> NOP cycles 0..19999; PRECHARGE (bank 3, addr 1FFF) at cycle 20000 only.
REQ-029 Same run -> AUTO REFRESH at cycles 20002, 20009, ..., 20051 (exactly 8), NOP between.
REQ-030 Same run -> LOAD MODE at 20058 with bank 0, addr 13'h0037; init_end rises at 20061 and stays high 1000 further cycles.
REQ-031 Drop rstn at cycle 20030 (mid-refresh) -> outputs reset asynchronously; after release PRECHARGE again 20000 cycles later, init_end stays 0 until new sequence completes.
REQ-032 SDRAM_INIT_FAST_SIM_EN defined -> PRECHARGE at cycle 200, LOAD MODE at 258, init_end at 261.
REQ-033 Connect to a W9825G6KH behavioural model (CKE=1, DQM=0) -> model reports no timing violations and mode CL=3, full-page sequential burst.
